// File: rtl/if_stage.sv
// Instruction-fetch stage: PC register, BOOT/RUN/HALT sequencer and IF/ID pipeline register.
// Redirects beat stall for the PC; fetch stops once the sequential PC would pass PC_LIMIT.
module if_stage #(
    parameter logic [31:0] RESET_PC = 32'd0,
    parameter logic [31:0] PC_LIMIT = 32'd60
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        stall,
    input  logic        flush,
    input  logic        branch_taken,
    input  logic [31:0] branch_target,
    input  logic        jump,
    input  logic [31:0] jump_target,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_instruction,
    output logic [31:0] ifid_instruction,
    output logic [31:0] ifid_pc_plus4,
    output logic        ifid_valid,
    output logic        halted
);

    typedef enum logic [1:0] {
        BOOT = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] ifid_instr_q, ifid_instr_d;
    logic [31:0] ifid_pc4_q, ifid_pc4_d;
    logic        ifid_valid_q, ifid_valid_d;

    logic        redirect;
    logic [31:0] redirect_target;
    logic [31:0] pc_plus4;

    assign redirect        = branch_taken | jump;
    // Branch wins over jump; targets are word-aligned by dropping the low bits.
    assign redirect_target = (branch_taken ? branch_target : jump_target) & 32'hFFFF_FFFC;
    assign pc_plus4        = pc_q + 32'd4;

    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        ifid_instr_d = ifid_instr_q;
        ifid_pc4_d   = ifid_pc4_q;
        ifid_valid_d = ifid_valid_q;

        case (state_q)
            BOOT: begin
                pc_d         = RESET_PC;
                ifid_instr_d = 32'd0;
                ifid_pc4_d   = 32'd0;
                ifid_valid_d = 1'b0;
                state_d      = RUN;
            end
            RUN: begin
                if (redirect) begin
                    pc_d         = redirect_target;
                    ifid_instr_d = 32'd0;
                    ifid_pc4_d   = 32'd0;
                    ifid_valid_d = 1'b0;
                    if (redirect_target > PC_LIMIT) begin
                        state_d = HALT;
                    end
                end else begin
                    if (flush) begin
                        ifid_instr_d = 32'd0;
                        ifid_pc4_d   = 32'd0;
                        ifid_valid_d = 1'b0;
                    end else if (!stall) begin
                        ifid_instr_d = imem_instruction;
                        ifid_pc4_d   = pc_plus4;
                        ifid_valid_d = 1'b1;
                    end
                    // The last word is still latched above; only the PC stops advancing.
                    if (!stall) begin
                        if (pc_plus4 > PC_LIMIT) begin
                            state_d = HALT;
                        end else begin
                            pc_d = pc_plus4;
                        end
                    end
                end
            end
            HALT: begin
                if (flush || !stall) begin
                    ifid_instr_d = 32'd0;
                    ifid_pc4_d   = 32'd0;
                    ifid_valid_d = 1'b0;
                end
            end
            default: begin
                state_d = BOOT;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q      <= BOOT;
            pc_q         <= RESET_PC;
            ifid_instr_q <= 32'd0;
            ifid_pc4_q   <= 32'd0;
            ifid_valid_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            ifid_instr_q <= ifid_instr_d;
            ifid_pc4_q   <= ifid_pc4_d;
            ifid_valid_q <= ifid_valid_d;
        end
    end

    assign imem_addr        = pc_q;
    assign ifid_instruction = ifid_instr_q;
    assign ifid_pc_plus4    = ifid_pc4_q;
    assign ifid_valid       = ifid_valid_q;
    assign halted           = (state_q == HALT);

endmodule

// File: tb/tb_if_stage.sv
// Directed bench for if_stage: a 64-word instruction store model with hand-computed expectations.
module tb_if_stage;

    logic        clock;
    logic        reset;
    logic        stall;
    logic        flush;
    logic        branch_taken;
    logic [31:0] branch_target;
    logic        jump;
    logic [31:0] jump_target;
    logic [31:0] imem_addr;
    logic [31:0] imem_instruction;
    logic [31:0] ifid_instruction;
    logic [31:0] ifid_pc_plus4;
    logic        ifid_valid;
    logic        halted;

    logic [31:0] mem [64];
    int          err_cnt = 0;
    int          chk_cnt = 0;

    if_stage dut (
        .clock            (clock),
        .reset            (reset),
        .stall            (stall),
        .flush            (flush),
        .branch_taken     (branch_taken),
        .branch_target    (branch_target),
        .jump             (jump),
        .jump_target      (jump_target),
        .imem_addr        (imem_addr),
        .imem_instruction (imem_instruction),
        .ifid_instruction (ifid_instruction),
        .ifid_pc_plus4    (ifid_pc_plus4),
        .ifid_valid       (ifid_valid),
        .halted           (halted)
    );

    assign imem_instruction = (imem_addr <= 32'd60) ? mem[imem_addr[7:2]] : 32'd0;

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        chk_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %08h expected %08h", tag, got, exp);
        end else begin
            $display("ok   %s: %08h", tag, got);
        end
    endtask

    // Advance one rising edge; inputs change and outputs are sampled on the falling edge.
    task automatic tick();
        @(posedge clock);
        @(negedge clock);
    endtask

    task automatic check_ifid(input string tag, input logic [31:0] addr, input logic [31:0] instr,
                              input logic [31:0] pc4, input logic valid, input logic hlt);
        check({tag, ".addr"},  imem_addr, addr);
        check({tag, ".instr"}, ifid_instruction, instr);
        check({tag, ".pc4"},   ifid_pc_plus4, pc4);
        check({tag, ".valid"}, {31'd0, ifid_valid}, {31'd0, valid});
        check({tag, ".halt"},  {31'd0, halted}, {31'd0, hlt});
    endtask

    initial begin
        for (int i = 0; i < 64; i++) mem[i] = 32'hA000_0000 + i;
        reset = 1'b0; stall = 1'b0; flush = 1'b0;
        branch_taken = 1'b0; branch_target = 32'd0; jump = 1'b0; jump_target = 32'd0;

        #12;
        check_ifid("reset", 32'd0, 32'd0, 32'd0, 1'b0, 1'b0);
        @(negedge clock);
        reset = 1'b1;

        tick(); check_ifid("boot", 32'd0, 32'd0, 32'd0, 1'b0, 1'b0);
        tick(); check_ifid("seq0", 32'd4, 32'hA000_0000, 32'd4, 1'b1, 1'b0);
        tick(); check_ifid("seq4", 32'd8, 32'hA000_0001, 32'd8, 1'b1, 1'b0);

        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick(); check_ifid($sformatf("stall%0d", i), 32'd8, 32'hA000_0001, 32'd8, 1'b1, 1'b0);
        end
        stall = 1'b0;
        tick(); check_ifid("resume", 32'd12, 32'hA000_0002, 32'd12, 1'b1, 1'b0);

        stall = 1'b1; branch_taken = 1'b1; branch_target = 32'h0000_0006;
        tick(); check_ifid("br_ovr_stall", 32'd4, 32'd0, 32'd0, 1'b0, 1'b0);
        stall = 1'b0; branch_taken = 1'b0;
        tick(); check_ifid("after_br", 32'd8, 32'hA000_0001, 32'd8, 1'b1, 1'b0);

        branch_taken = 1'b1; branch_target = 32'd0; jump = 1'b1; jump_target = 32'd40;
        tick(); check_ifid("br_vs_jmp", 32'd0, 32'd0, 32'd0, 1'b0, 1'b0);
        branch_taken = 1'b0; jump = 1'b0;
        tick(); check_ifid("fetch0", 32'd4, 32'hA000_0000, 32'd4, 1'b1, 1'b0);

        flush = 1'b1; stall = 1'b1;
        tick(); check_ifid("flush_stall", 32'd4, 32'd0, 32'd0, 1'b0, 1'b0);
        flush = 1'b0; stall = 1'b0;

        jump = 1'b1; jump_target = 32'd48;
        tick(); check_ifid("jmp48", 32'd48, 32'd0, 32'd0, 1'b0, 1'b0);
        jump = 1'b0;
        tick(); check_ifid("w48", 32'd52, 32'hA000_000C, 32'd52, 1'b1, 1'b0);
        tick(); check_ifid("w52", 32'd56, 32'hA000_000D, 32'd56, 1'b1, 1'b0);
        tick(); check_ifid("w56", 32'd60, 32'hA000_000E, 32'd60, 1'b1, 1'b0);
        tick(); check_ifid("w60", 32'd60, 32'hA000_000F, 32'd64, 1'b1, 1'b1);
        tick(); check_ifid("halt_nop", 32'd60, 32'd0, 32'd0, 1'b0, 1'b1);
        jump = 1'b1; jump_target = 32'd0;
        tick(); check_ifid("halt_jmp", 32'd60, 32'd0, 32'd0, 1'b0, 1'b1);
        jump = 1'b0;

        #2 reset = 1'b0;
        #1 check_ifid("rst_halt", 32'd0, 32'd0, 32'd0, 1'b0, 1'b0);
        @(negedge clock);
        reset = 1'b1;
        tick(); check_ifid("boot2", 32'd0, 32'd0, 32'd0, 1'b0, 1'b0);
        jump = 1'b1; jump_target = 32'd100;
        tick();
        check("jmp_far.halt",  {31'd0, halted}, 32'd1);
        check("jmp_far.valid", {31'd0, ifid_valid}, 32'd0);
        check("jmp_far.instr", ifid_instruction, 32'd0);
        jump = 1'b0;

        reset = 1'b0;
        @(negedge clock);
        reset = 1'b1;
        tick();
        for (int i = 0; i < 6; i++) tick();
        check_ifid("pc24", 32'd24, 32'hA000_0005, 32'd24, 1'b1, 1'b0);
        #2 reset = 1'b0;
        #1 check_ifid("rst_run", 32'd0, 32'd0, 32'd0, 1'b0, 1'b0);
        @(negedge clock);
        check_ifid("rst_hold", 32'd0, 32'd0, 32'd0, 1'b0, 1'b0);

        $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
        $finish;
    end

endmodule
